// File: rtl/ones_comp_serial_sub.sv
// Bit-serial ones' complement subtractor: Diff = A - B computed as A + ~B
// with end-around carry, one bit per clock, LSB first. A second serial pass
// (WRAP) folds the end-around carry back in when the first pass carries out.
module ones_comp_serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             negative,
  output logic             neg_zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    WRAP,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
  logic             carry, carry_nxt;
  logic             a_sign, b_sign;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             sum_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the serial full-adder slice. WRAP reuses the same result
  // rotation with b=0; the SUB carry-out (1 when WRAP is taken) is exactly the
  // carry-in that WRAP needs at bit 0.
  always_comb begin
    state_nxt = state;
    sum_bit   = 1'b0;
    carry_nxt = carry;
    r_nxt     = r_sr;
    case (state)
      IDLE: if (start) state_nxt = SUB;
      SUB: begin
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        r_nxt     = {sum_bit, r_sr[WIDTH-1:1]};
        if (last_bit) state_nxt = carry_nxt ? WRAP : DONE;
      end
      WRAP: begin
        sum_bit   = r_sr[0] ^ carry;
        carry_nxt = r_sr[0] & carry;
        r_nxt     = {sum_bit, r_sr[WIDTH-1:1]};
        if (last_bit) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= ~B;
            a_sign <= A[WIDTH-1];
            b_sign <= B[WIDTH-1];
            r_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
          end
        end
        SUB: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_nxt;
          carry <= carry_nxt;
          cnt   <= last_bit ? '0 : cnt + CW'(1);
        end
        WRAP: begin
          r_sr  <= r_nxt;
          carry <= carry_nxt;
          cnt   <= last_bit ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result and flags load together on the edge that enters DONE, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff     <= '0;
      negative <= 1'b0;
      neg_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (state_nxt == DONE && state != DONE) begin
      Diff     <= r_nxt;
      negative <= r_nxt[WIDTH-1];
      neg_zero <= &r_nxt;
      overflow <= (a_sign ^ b_sign) & (r_nxt[WIDTH-1] ^ a_sign);
    end
  end

endmodule

// File: tb/tb_ones_comp_serial_sub.sv
// Randomised and directed bench for ones_comp_serial_sub (WIDTH=4).
module tb_ones_comp_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, negative, neg_zero, overflow;
  logic [W-1:0] Diff;

  int n_checks = 0;
  int n_fail   = 0;

  ones_comp_serial_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Diff     (Diff),
    .negative (negative),
    .neg_zero (neg_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: {wrap, diff, negative, neg_zero, overflow} from plain arithmetic.
  function automatic logic [W+3:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] d;
    s = {1'b0, a} + {1'b0, ~b};
    d = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    return {s[W], d, d[W-1], &d, (a[W-1] != b[W-1]) && (d[W-1] != a[W-1])};
  endfunction

  // One operation. cyc = cycle in which done is seen (first cycle after the
  // accepting edge is 1). With scramble, start and A/B toggle randomly while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                       output logic [W+2:0] res, output int cyc, output int done_w,
                       output logic busy_after);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3*W + 4) begin
      if (scramble) begin
        A = W'($urandom); B = W'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    res = {Diff, negative, neg_zero, overflow};
    done_w = done ? 1 : 0;
    @(posedge clk); #1;
    if (done) done_w++;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, Diff, negative, neg_zero, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b Diff=%b flags=%b%b%b, want all zero",
               busy, done, Diff, negative, neg_zero, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[4] = '{4'b0101, 4'b0011, 4'b0110, 4'b0111};
    logic [W-1:0] vb[4] = '{4'b0011, 4'b0101, 4'b0110, 4'b1000};
    logic [W+2:0] vx[4] = '{{4'b0010, 3'b000}, {4'b1101, 3'b100},
                           {4'b1111, 3'b110}, {4'b1110, 3'b101}};
    int           vl[4] = '{2*W+1, W+1, W+1, W+1};
    logic [W+2:0] res;
    int           cyc, dw;
    logic         ba;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b0, res, cyc, dw, ba);
      n_checks++;
      if (res !== vx[i]) begin
        n_fail++;
        $display("FAIL vec%0d_result: got {Diff,neg,nz,ov}=%b want %b", i, res, vx[i]);
      end
      n_checks++;
      if (cyc !== vl[i]) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got %0d want %0d", i, cyc, vl[i]);
      end
      n_checks++;
      if (dw !== 1 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_done_pulse: got width=%0d busy_after=%b want 1/0", i, dw, ba);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [W+3:0] exp;
    logic [W+2:0] res;
    int           cyc, dw, lat;
    logic         ba;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp = ref_model(a, b);
      lat = exp[W+3] ? 2*W+1 : W+1;
      do_op(a, b, 1'b1, res, cyc, dw, ba);
      n_checks++;
      if (res !== exp[W+2:0] || cyc !== lat || dw !== 1 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d a=%b b=%b: got res=%b lat=%0d dw=%0d busy_after=%b want res=%b lat=%0d dw=1 busy_after=0",
                 i, a, b, res, cyc, dw, ba, exp[W+2:0], lat);
      end
    end
  endtask

  task automatic test_abort();
    logic [W+2:0] res;
    int           cyc, dw;
    logic         ba;
    bit           seen;
    do_op(4'b0101, 4'b0011, 1'b0, res, cyc, dw, ba);
    @(negedge clk);
    A = 4'b0011; B = 4'b0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Diff !== '0 || {negative, neg_zero, overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_immediate: got busy=%b done=%b Diff=%b flags=%b%b%b want all zero",
               busy, done, Diff, negative, neg_zero, overflow);
    end
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2*W + 3) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_done: got done/busy activity=1 want 0");
    end
    do_op(4'b0001, 4'b0001, 1'b0, res, cyc, dw, ba);
    n_checks++;
    if (res !== {4'b1111, 3'b110} || cyc !== W+1) begin
      n_fail++;
      $display("FAIL abort_recover: got res=%b lat=%0d want %b lat=%0d", res, cyc, {4'b1111, 3'b110}, W+1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+3:0] e1, e2;
    logic [W+2:0] r1, r2;
    int           cyc, gap;
    for (int k = 0; k < 4; k++) begin
      a1 = W'($urandom); b1 = W'($urandom);
      do begin
        a2 = W'($urandom); b2 = W'($urandom);
      end while (ref_model(a2, b2) == ref_model(a1, b1));
      e1 = ref_model(a1, b1);
      e2 = ref_model(a2, b2);
      @(negedge clk);
      A = a1; B = b1; start = 1'b1;
      @(posedge clk); #1;
      A = a2; B = b2;
      cyc = 1;
      while (!done && cyc < 3*W + 4) begin
        @(posedge clk); #1;
        cyc++;
      end
      r1 = {Diff, negative, neg_zero, overflow};
      gap = 0;
      while (gap < 4) begin
        @(posedge clk); #1;
        if (busy) break;
        gap++;
      end
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 3*W + 4) begin
        @(posedge clk); #1;
        cyc++;
      end
      r2 = {Diff, negative, neg_zero, overflow};
      n_checks++;
      if (r1 !== e1[W+2:0] || r2 !== e2[W+2:0]) begin
        n_fail++;
        $display("FAIL b2b%0d_results: got r1=%b r2=%b want %b %b", k, r1, r2, e1[W+2:0], e2[W+2:0]);
      end
      n_checks++;
      if (gap !== 1) begin
        n_fail++;
        $display("FAIL b2b%0d_idle_gap: got %0d cycles want 1", k, gap);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
